bcd_add_datapath: RTL and testbench

BCD_ADD_DATAPATH -- requirements
Module: bcd_add_datapath

---
 rtl/bcd_add_pkg.sv | 36 +++
 rtl/bcd_digit_adder.sv | 25 ++
 rtl/bcd_add_datapath.sv | 143 ++++++++++++++
 tb/tb_bcd_add_datapath.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_add_pkg.sv
// Shared definitions for the BCD adder datapath: FSM encoding, request
// priority indices and digit helpers.
package bcd_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ADD_HI   = 2'd1,
    ST_ACK_WAIT = 2'd2
  } state_t;

  // Lower index wins when several requests are raised together.
  localparam logic [2:0] REQ_INIT      = 3'd0;
  localparam logic [2:0] REQ_LOAD_A    = 3'd1;
  localparam logic [2:0] REQ_LOAD_B    = 3'd2;
  localparam logic [2:0] REQ_DISP_A    = 3'd3;
  localparam logic [2:0] REQ_DISP_B    = 3'd4;
  localparam logic [2:0] REQ_ADD       = 3'd5;
  localparam logic [2:0] REQ_RESULT_LS = 3'd6;
  localparam logic [2:0] REQ_RESULT_MS = 3'd7;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  function automatic logic [2:0] req_pick(input logic [7:0] req);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : d;
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Single BCD digit adder with decimal correction.
// Combinational, zero latency; no flow control.
// Result digit is valid for any a+b+cin up to 19.
module bcd_digit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] digit,
  output logic       cout
);

  logic [4:0] sum;

  always_comb begin
    sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (sum > 5'd9) begin
      digit = sum[3:0] + 4'd6;
      cout  = 1'b1;
    end else begin
      digit = sum[3:0];
      cout  = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_add_datapath.sv
// Two-digit BCD operand/result datapath served by a four-phase request/ACK handshake.
// Latency: 1 cycle request->ACK, 2 cycles for ADD; ACK holds until its request drops.
module bcd_add_datapath
  import bcd_add_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] SW,
  input  logic       BCD_INIT,
  input  logic       BCD_LOAD_A,
  input  logic       BCD_LOAD_B,
  input  logic       BCD_DISPLAY_A,
  input  logic       BCD_DISPLAY_B,
  input  logic       BCD_ADD,
  input  logic       BCD_DISPLAY_RESULT_LS,
  input  logic       BCD_DISPLAY_RESULT_MS,
  output logic       BCD_INIT_ACK,
  output logic       BCD_LOAD_A_ACK,
  output logic       BCD_LOAD_B_ACK,
  output logic       BCD_DISPLAY_A_ACK,
  output logic       BCD_DISPLAY_B_ACK,
  output logic       BCD_ADD_ACK,
  output logic       BCD_DISPLAY_RESULT_LS_ACK,
  output logic       BCD_DISPLAY_RESULT_MS_ACK,
  output logic [7:0] DISPLAY,
  output logic       BCD_ERR
);

  state_t     state_q;
  logic [7:0] a_q, b_q, ls_q, display_q, ack_q;
  logic [3:0] ms_q;
  logic       carry_q, err_q;
  logic [2:0] served_q;

  logic [7:0] req;
  logic [2:0] pick;
  logic [7:0] sw_clamped;
  logic       sw_bad;
  logic       add_hi;
  logic [3:0] add_a, add_b, add_digit;
  logic       add_cin, add_cout;

  assign req = {BCD_DISPLAY_RESULT_MS, BCD_DISPLAY_RESULT_LS, BCD_ADD, BCD_DISPLAY_B,
                BCD_DISPLAY_A, BCD_LOAD_B, BCD_LOAD_A, BCD_INIT};
  assign pick = req_pick(req);

  assign sw_clamped = {clamp_digit(SW[7:4]), clamp_digit(SW[3:0])};
  assign sw_bad     = (SW[7:4] > BCD_MAX_DIGIT) || (SW[3:0] > BCD_MAX_DIGIT);

  // One digit adder: units digits while idle, tens digits plus carry in ADD_HI.
  assign add_hi  = (state_q == ST_ADD_HI);
  assign add_a   = add_hi ? a_q[7:4] : a_q[3:0];
  assign add_b   = add_hi ? b_q[7:4] : b_q[3:0];
  assign add_cin = add_hi & carry_q;

  bcd_digit_adder u_digit_adder (
    .a     (add_a),
    .b     (add_b),
    .cin   (add_cin),
    .digit (add_digit),
    .cout  (add_cout)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      ls_q      <= 8'h00;
      ms_q      <= 4'h0;
      carry_q   <= 1'b0;
      display_q <= 8'h00;
      err_q     <= 1'b0;
      ack_q     <= 8'h00;
      served_q  <= 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            served_q <= pick;
            if (pick == REQ_ADD) begin
              ls_q[3:0] <= add_digit;
              carry_q   <= add_cout;
              state_q   <= ST_ADD_HI;
            end else begin
              ack_q[pick] <= 1'b1;
              state_q     <= ST_ACK_WAIT;
              case (pick)
                REQ_INIT: begin
                  a_q       <= 8'h00;
                  b_q       <= 8'h00;
                  ls_q      <= 8'h00;
                  ms_q      <= 4'h0;
                  carry_q   <= 1'b0;
                  display_q <= 8'h00;
                  err_q     <= 1'b0;
                end
                REQ_LOAD_A: begin
                  a_q   <= sw_clamped;
                  err_q <= err_q | sw_bad;
                end
                REQ_LOAD_B: begin
                  b_q   <= sw_clamped;
                  err_q <= err_q | sw_bad;
                end
                REQ_DISP_A:    display_q <= a_q;
                REQ_DISP_B:    display_q <= b_q;
                REQ_RESULT_LS: display_q <= ls_q;
                REQ_RESULT_MS: display_q <= {4'h0, ms_q};
                default: ;
              endcase
            end
          end
        end
        ST_ADD_HI: begin
          ls_q[7:4]      <= add_digit;
          ms_q           <= {3'b000, add_cout};
          ack_q[REQ_ADD] <= 1'b1;
          state_q        <= ST_ACK_WAIT;
        end
        ST_ACK_WAIT: begin
          if (!req[served_q]) begin
            ack_q   <= 8'h00;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign BCD_INIT_ACK              = ack_q[REQ_INIT];
  assign BCD_LOAD_A_ACK            = ack_q[REQ_LOAD_A];
  assign BCD_LOAD_B_ACK            = ack_q[REQ_LOAD_B];
  assign BCD_DISPLAY_A_ACK         = ack_q[REQ_DISP_A];
  assign BCD_DISPLAY_B_ACK         = ack_q[REQ_DISP_B];
  assign BCD_ADD_ACK               = ack_q[REQ_ADD];
  assign BCD_DISPLAY_RESULT_LS_ACK = ack_q[REQ_RESULT_LS];
  assign BCD_DISPLAY_RESULT_MS_ACK = ack_q[REQ_RESULT_MS];
  assign DISPLAY                   = display_q;
  assign BCD_ERR                   = err_q;

endmodule

// File: tb/tb_bcd_add_datapath.sv
// Directed bench for bcd_add_datapath: handshake timing, BCD arithmetic,
// error flag, request priority and reset abort.
module tb_bcd_add_datapath;
  import bcd_add_pkg::*;

  logic       CLK;
  logic       RESET;
  logic [7:0] SW;
  logic [7:0] req;
  logic [7:0] ack;
  logic [7:0] DISPLAY;
  logic       BCD_ERR;

  int errors = 0;
  int checks = 0;

  bcd_add_datapath dut (
    .CLK                       (CLK),
    .RESET                     (RESET),
    .SW                        (SW),
    .BCD_INIT                  (req[0]),
    .BCD_LOAD_A                (req[1]),
    .BCD_LOAD_B                (req[2]),
    .BCD_DISPLAY_A             (req[3]),
    .BCD_DISPLAY_B             (req[4]),
    .BCD_ADD                   (req[5]),
    .BCD_DISPLAY_RESULT_LS     (req[6]),
    .BCD_DISPLAY_RESULT_MS     (req[7]),
    .BCD_INIT_ACK              (ack[0]),
    .BCD_LOAD_A_ACK            (ack[1]),
    .BCD_LOAD_B_ACK            (ack[2]),
    .BCD_DISPLAY_A_ACK         (ack[3]),
    .BCD_DISPLAY_B_ACK         (ack[4]),
    .BCD_ADD_ACK               (ack[5]),
    .BCD_DISPLAY_RESULT_LS_ACK (ack[6]),
    .BCD_DISPLAY_RESULT_MS_ACK (ack[7]),
    .DISPLAY                   (DISPLAY),
    .BCD_ERR                   (BCD_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Full four-phase handshake on one request, checking ACK latency and exclusivity.
  task automatic do_op(input logic [2:0] idx, input logic [7:0] sw, input int exp_lat);
    int lat;
    logic [7:0] onehot;
    onehot = 8'h01 << idx;
    lat = 0;
    @(negedge CLK);
    SW = sw;
    req[idx] = 1'b1;
    do begin
      @(negedge CLK);
      lat++;
    end while (ack[idx] !== 1'b1 && lat < 20);
    checks++;
    if (lat != exp_lat || ack[idx] !== 1'b1) begin
      errors++;
      $display("FAIL ack_latency req=%0d: got %0d cycles (ack=%b), want %0d", idx, lat, ack[idx], exp_lat);
    end
    checks++;
    if (ack !== onehot) begin
      errors++;
      $display("FAIL ack_onehot req=%0d: got %b, want %b", idx, ack, onehot);
    end
    req[idx] = 1'b0;
    @(negedge CLK);
    checks++;
    if (ack !== 8'h00) begin
      errors++;
      $display("FAIL ack_release req=%0d: got %b, want 00000000", idx, ack);
    end
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    SW = 8'h00;
    req = 8'h00;
    #12;
    checks++;
    if (ack !== 8'h00) begin errors++; $display("FAIL reset_ack: got %b, want 0", ack); end
    checks++;
    if (DISPLAY !== 8'h00) begin errors++; $display("FAIL reset_display: got %h, want 00", DISPLAY); end
    checks++;
    if (BCD_ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, want 0", BCD_ERR); end
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_basic_add;
    do_op(REQ_LOAD_A, 8'h47, 1);
    do_op(REQ_LOAD_B, 8'h58, 1);
    do_op(REQ_ADD, 8'h00, 2);
    checks++;
    if (DISPLAY !== 8'h00) begin errors++; $display("FAIL display_stable: got %h, want 00", DISPLAY); end
    do_op(REQ_RESULT_LS, 8'h00, 1);
    checks++;
    if (DISPLAY !== 8'h05) begin errors++; $display("FAIL add47_58_ls: got %h, want 05", DISPLAY); end
    do_op(REQ_RESULT_MS, 8'h00, 1);
    checks++;
    if (DISPLAY !== 8'h01) begin errors++; $display("FAIL add47_58_ms: got %h, want 01", DISPLAY); end
  endtask

  task automatic test_extremes;
    do_op(REQ_LOAD_A, 8'h99, 1);
    do_op(REQ_LOAD_B, 8'h99, 1);
    do_op(REQ_ADD, 8'h00, 2);
    do_op(REQ_RESULT_LS, 8'h00, 1);
    checks++;
    if (DISPLAY !== 8'h98) begin errors++; $display("FAIL add99_99_ls: got %h, want 98", DISPLAY); end
    do_op(REQ_RESULT_MS, 8'h00, 1);
    checks++;
    if (DISPLAY !== 8'h01) begin errors++; $display("FAIL add99_99_ms: got %h, want 01", DISPLAY); end
    do_op(REQ_LOAD_A, 8'h00, 1);
    do_op(REQ_LOAD_B, 8'h00, 1);
    do_op(REQ_ADD, 8'h00, 2);
    do_op(REQ_RESULT_LS, 8'h00, 1);
    checks++;
    if (DISPLAY !== 8'h00) begin errors++; $display("FAIL add00_00_ls: got %h, want 00", DISPLAY); end
    do_op(REQ_RESULT_MS, 8'h00, 1);
    checks++;
    if (DISPLAY !== 8'h00) begin errors++; $display("FAIL add00_00_ms: got %h, want 00", DISPLAY); end
    checks++;
    if (BCD_ERR !== 1'b0) begin errors++; $display("FAIL err_clean: got %b, want 0", BCD_ERR); end
  endtask

  task automatic test_bcd_error;
    do_op(REQ_LOAD_A, 8'h3A, 1);
    do_op(REQ_DISP_A, 8'h00, 1);
    checks++;
    if (DISPLAY !== 8'h39) begin errors++; $display("FAIL clamp_a: got %h, want 39", DISPLAY); end
    checks++;
    if (BCD_ERR !== 1'b1) begin errors++; $display("FAIL err_set: got %b, want 1", BCD_ERR); end
    do_op(REQ_LOAD_B, 8'hF2, 1);
    do_op(REQ_DISP_B, 8'h00, 1);
    checks++;
    if (DISPLAY !== 8'h92) begin errors++; $display("FAIL clamp_b: got %h, want 92", DISPLAY); end
    do_op(REQ_LOAD_B, 8'h12, 1);
    checks++;
    if (BCD_ERR !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b, want 1", BCD_ERR); end
    do_op(REQ_INIT, 8'h00, 1);
    checks++;
    if (BCD_ERR !== 1'b0) begin errors++; $display("FAIL init_err: got %b, want 0", BCD_ERR); end
    checks++;
    if (DISPLAY !== 8'h00) begin errors++; $display("FAIL init_display: got %h, want 00", DISPLAY); end
  endtask

  task automatic test_priority;
    @(negedge CLK);
    SW = 8'h21;
    req[REQ_LOAD_A] = 1'b1;
    req[REQ_LOAD_B] = 1'b1;
    @(negedge CLK);
    checks++;
    if (ack !== 8'h02) begin errors++; $display("FAIL prio_first: got %b, want 00000010", ack); end
    SW = 8'h43;
    req[REQ_LOAD_A] = 1'b0;
    @(negedge CLK);
    checks++;
    if (ack !== 8'h00) begin errors++; $display("FAIL prio_release: got %b, want 00000000", ack); end
    @(negedge CLK);
    checks++;
    if (ack !== 8'h04) begin errors++; $display("FAIL prio_pending: got %b, want 00000100", ack); end
    req[REQ_LOAD_B] = 1'b0;
    @(negedge CLK);
    do_op(REQ_DISP_A, 8'h00, 1);
    checks++;
    if (DISPLAY !== 8'h21) begin errors++; $display("FAIL prio_a_val: got %h, want 21", DISPLAY); end
    do_op(REQ_DISP_B, 8'h00, 1);
    checks++;
    if (DISPLAY !== 8'h43) begin errors++; $display("FAIL prio_b_val: got %h, want 43", DISPLAY); end
  endtask

  task automatic test_reset_mid_add;
    do_op(REQ_LOAD_A, 8'h55, 1);
    do_op(REQ_LOAD_B, 8'h55, 1);
    do_op(REQ_ADD, 8'h00, 2);
    @(negedge CLK);
    req[REQ_ADD] = 1'b1;
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    req[REQ_ADD] = 1'b0;
    #1;
    checks++;
    if (ack !== 8'h00) begin errors++; $display("FAIL abort_ack: got %b, want 0", ack); end
    #1;
    RESET = 1'b0;
    do_op(REQ_RESULT_LS, 8'h00, 1);
    checks++;
    if (DISPLAY !== 8'h00) begin errors++; $display("FAIL abort_ls: got %h, want 00", DISPLAY); end
    do_op(REQ_RESULT_MS, 8'h00, 1);
    checks++;
    if (DISPLAY !== 8'h00) begin errors++; $display("FAIL abort_ms: got %h, want 00", DISPLAY); end
    do_op(REQ_LOAD_A, 8'h12, 1);
    do_op(REQ_LOAD_B, 8'h34, 1);
    do_op(REQ_ADD, 8'h00, 2);
    do_op(REQ_RESULT_LS, 8'h00, 1);
    checks++;
    if (DISPLAY !== 8'h46) begin errors++; $display("FAIL add12_34_ls: got %h, want 46", DISPLAY); end
  endtask

  task automatic test_hold_and_pulse;
    int cnt;
    cnt = 0;
    @(negedge CLK);
    req[REQ_DISP_A] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (ack[REQ_DISP_A] === 1'b1) cnt++;
    end
    req[REQ_DISP_A] = 1'b0;
    checks++;
    if (cnt != 10) begin errors++; $display("FAIL hold_cycles: got %0d, want 10", cnt); end
    @(negedge CLK);
    checks++;
    if (ack !== 8'h00) begin errors++; $display("FAIL hold_drop: got %b, want 0", ack); end
    checks++;
    if (DISPLAY !== 8'h12) begin errors++; $display("FAIL hold_display: got %h, want 12", DISPLAY); end
    req[REQ_ADD] = 1'b1;
    @(negedge CLK);
    req[REQ_ADD] = 1'b0;
    checks++;
    if (ack !== 8'h00) begin errors++; $display("FAIL pulse_addhi: got %b, want 0", ack); end
    @(negedge CLK);
    checks++;
    if (ack !== 8'h20) begin errors++; $display("FAIL pulse_high: got %b, want 00100000", ack); end
    @(negedge CLK);
    checks++;
    if (ack !== 8'h00) begin errors++; $display("FAIL pulse_low: got %b, want 0", ack); end
    do_op(REQ_RESULT_LS, 8'h00, 1);
    checks++;
    if (DISPLAY !== 8'h46) begin errors++; $display("FAIL pulse_result: got %h, want 46", DISPLAY); end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_extremes();
    test_bcd_error();
    test_priority();
    test_reset_mid_add();
    test_hold_and_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
